// File: rtl/sdio_clk_ctrl.sv
// SD card clock generator: divides clk_i, starts/pauses/stops the card clock
// only while it is low, and emits edge strobes and burst-complete pulses.
//
// state | meaning
// ------+------------------------------------------------------------
// OFF   | no card clock, waiting for free-run request or burst start
// RUN   | card clock toggling, gating enable asserted
// PAUSE | clock parked low by data-path back-pressure
// BDONE | burst finished, burst_done_o pulses for one cycle
module sdio_clk_ctrl #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               clk_req_i,
  input  logic               stop_req_i,
  input  logic               burst_start_i,
  input  logic [BURST_W-1:0] burst_len_i,
  output logic               sd_clk_o,
  output logic               clk_en_o,
  output logic               pos_edge_o,
  output logic               neg_edge_o,
  output logic               clk_stopped_o,
  output logic               burst_done_o
);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_PAUSE, S_BDONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] bcnt_q;
  logic               burst_q;
  logic               sd_clk_q;
  logic               pos_q;
  logic               neg_q;

  logic tick, rise, fall, start_free, enter_run;

  assign tick       = (state_q == S_RUN) && (cnt_q == div_q);
  assign rise       = tick && !sd_clk_q;
  assign fall       = tick && sd_clk_q;
  assign start_free = clk_req_i && !stop_req_i;
  assign enter_run  = (state_q != S_RUN) && (state_d == S_RUN);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_OFF;
    else       state_q <= state_d;
  end

  // Every exit from RUN happens on a falling edge, so the clock never parks high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF: begin
        if (start_free)         state_d = S_RUN;
        else if (burst_start_i) state_d = (burst_len_i != '0) ? S_RUN : S_BDONE;
      end
      S_RUN: begin
        if (fall) begin
          if (burst_q && (bcnt_q == '0))   state_d = S_BDONE;
          else if (!burst_q && !clk_req_i) state_d = S_OFF;
          else if (stop_req_i)             state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (!burst_q && !clk_req_i) state_d = S_OFF;
        else if (!stop_req_i)       state_d = S_RUN;
      end
      S_BDONE: state_d = S_OFF;
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    clk_en_o      = 1'b0;
    clk_stopped_o = 1'b1;
    burst_done_o  = 1'b0;
    case (state_q)
      S_RUN: begin
        clk_en_o      = 1'b1;
        clk_stopped_o = 1'b0;
      end
      S_BDONE: burst_done_o = 1'b1;
      default: ;
    endcase
  end

  // A new divider only applies from a fresh low half-period onward.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= '0;
      bcnt_q   <= '0;
      burst_q  <= 1'b0;
      sd_clk_q <= 1'b0;
      pos_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      pos_q <= rise;
      neg_q <= fall;
      if (tick) sd_clk_q <= !sd_clk_q;
      if ((state_q == S_RUN) && !tick) cnt_q <= cnt_q + 1'b1;
      else                             cnt_q <= '0;
      if (fall || enter_run) div_q <= div_i;
      if ((state_q == S_OFF) && (state_d != S_OFF)) begin
        burst_q <= !start_free;
        bcnt_q  <= start_free ? '0 : burst_len_i;
      end else if (rise && burst_q) begin
        bcnt_q <= bcnt_q - 1'b1;
      end
    end
  end

  assign sd_clk_o   = sd_clk_q;
  assign pos_edge_o = pos_q;
  assign neg_edge_o = neg_q;

endmodule

// File: tb/tb_sdio_clk_ctrl.sv
// Bench for sdio_clk_ctrl: directed scenarios plus random stimulus, all
// outputs compared every cycle against a half-period-countdown model.
module tb_sdio_clk_ctrl;

  localparam int M_OFF = 0, M_RUN = 1, M_PAUSE = 2, M_BDONE = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] div_i;
  logic       clk_req_i, stop_req_i, burst_start_i;
  logic [7:0] burst_len_i;
  logic       sd_clk_o, clk_en_o, pos_edge_o, neg_edge_o, clk_stopped_o, burst_done_o;

  sdio_clk_ctrl #(.DIV_W(8), .BURST_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .div_i(div_i), .clk_req_i(clk_req_i),
    .stop_req_i(stop_req_i), .burst_start_i(burst_start_i), .burst_len_i(burst_len_i),
    .sd_clk_o(sd_clk_o), .clk_en_o(clk_en_o), .pos_edge_o(pos_edge_o),
    .neg_edge_o(neg_edge_o), .clk_stopped_o(clk_stopped_o), .burst_done_o(burst_done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0, n_fail = 0;
  int m_st, m_left, m_div, m_edges;
  bit m_lvl, m_pos, m_neg, m_burst;
  int c_pos, c_neg, c_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_left counts cycles remaining in the current half-period.
  task model_step();
    m_pos = 0;
    m_neg = 0;
    if (rst_i) begin
      m_st = M_OFF; m_lvl = 0; m_left = 0; m_div = 0; m_edges = 0; m_burst = 0;
      return;
    end
    case (m_st)
      M_OFF: begin
        if (clk_req_i && !stop_req_i) begin
          m_st = M_RUN; m_burst = 0; m_div = int'(div_i); m_left = m_div + 1;
        end else if (burst_start_i) begin
          if (burst_len_i != 0) begin
            m_st = M_RUN; m_burst = 1; m_edges = int'(burst_len_i);
            m_div = int'(div_i); m_left = m_div + 1;
          end else m_st = M_BDONE;
        end
      end
      M_RUN: begin
        m_left--;
        if (m_left == 0) begin
          if (!m_lvl) begin
            m_lvl = 1; m_pos = 1;
            if (m_burst) m_edges--;
            m_left = m_div + 1;
          end else begin
            m_lvl = 0; m_neg = 1;
            m_div = int'(div_i); m_left = m_div + 1;
            if (m_burst && m_edges == 0)  m_st = M_BDONE;
            else if (!m_burst && !clk_req_i) m_st = M_OFF;
            else if (stop_req_i)          m_st = M_PAUSE;
          end
        end
      end
      M_PAUSE: begin
        if (!m_burst && !clk_req_i) m_st = M_OFF;
        else if (!stop_req_i) begin
          m_st = M_RUN; m_div = int'(div_i); m_left = m_div + 1;
        end
      end
      default: m_st = M_OFF;
    endcase
  endtask

  task step();
    @(posedge clk_i);
    model_step();
    #1;
    chk("sd_clk", sd_clk_o, m_lvl);
    chk("clk_en", clk_en_o, m_st == M_RUN);
    chk("stopped", clk_stopped_o, m_st != M_RUN);
    chk("pos_edge", pos_edge_o, m_pos);
    chk("neg_edge", neg_edge_o, m_neg);
    chk("burst_done", burst_done_o, m_st == M_BDONE);
    c_pos += int'(pos_edge_o);
    c_neg += int'(neg_edge_o);
    c_done += int'(burst_done_o);
  endtask

  task wait_high(input string tag);
    for (int i = 0; i < 60 && !sd_clk_o; i++) step();
    chk(tag, sd_clk_o, 1);
  endtask

  task clear_counts();
    c_pos = 0; c_neg = 0; c_done = 0;
  endtask

  initial begin
    int hi, lo;
    rst_i = 1; div_i = 0; clk_req_i = 0; stop_req_i = 0; burst_start_i = 0; burst_len_i = 0;
    clear_counts();
    repeat (3) step();
    chk("rst_sd_clk", sd_clk_o, 0);
    chk("rst_clk_en", clk_en_o, 0);
    chk("rst_stopped", clk_stopped_o, 1);
    chk("rst_done", burst_done_o, 0);
    rst_i = 0;

    // div=0 free run
    clk_req_i = 1;
    step();
    chk("tp1_en_first", clk_en_o, 1);
    chk("tp1_low_first", sd_clk_o, 0);
    step();
    chk("tp1_rise_second", pos_edge_o, 1);
    repeat (10) step();
    clk_req_i = 0;
    repeat (6) step();

    // divider change during high phase
    div_i = 3; clk_req_i = 1;
    wait_high("tp2_wait");
    div_i = 1;
    hi = 0; while (sd_clk_o && hi < 20) begin hi++; step(); end
    chk("tp2_high_len", hi, 4);
    lo = 0; while (!sd_clk_o && lo < 20) begin lo++; step(); end
    chk("tp2_low_len", lo, 2);
    clk_req_i = 0;
    repeat (20) step();

    // stop request during high phase
    div_i = 2; clk_req_i = 1;
    wait_high("tp3_wait");
    stop_req_i = 1;
    hi = 0; while (sd_clk_o && hi < 20) begin hi++; step(); end
    chk("tp3_high_len", hi, 3);
    repeat (6) step();
    chk("tp3_parked_low", sd_clk_o, 0);
    chk("tp3_stopped", clk_stopped_o, 1);
    stop_req_i = 0;
    step();
    lo = 0; while (!sd_clk_o && lo < 20) begin lo++; step(); end
    chk("tp3_resume_low", lo, 3);
    clk_req_i = 0;
    repeat (20) step();

    // 8-clock burst
    clear_counts();
    div_i = 1; burst_len_i = 8; burst_start_i = 1;
    step();
    burst_start_i = 0;
    repeat (50) step();
    chk("tp4_pos_cnt", c_pos, 8);
    chk("tp4_neg_cnt", c_neg, 8);
    chk("tp4_done_cnt", c_done, 1);
    chk("tp4_end_low", sd_clk_o, 0);
    chk("tp4_end_off", clk_stopped_o, 1);

    // zero-length burst
    clear_counts();
    burst_len_i = 0; burst_start_i = 1;
    step();
    burst_start_i = 0;
    chk("tp5_done_next", burst_done_o, 1);
    repeat (4) step();
    chk("tp5_zero_pos", c_pos, 0);
    chk("tp5_zero_done", c_done, 1);

    // burst with a pause in the middle
    clear_counts();
    burst_len_i = 8; burst_start_i = 1;
    step();
    burst_start_i = 0;
    repeat (9) step();
    stop_req_i = 1;
    repeat (6) step();
    stop_req_i = 0;
    repeat (60) step();
    chk("tp5_pause_pos", c_pos, 8);
    chk("tp5_pause_done", c_done, 1);

    // reset while clock is high
    div_i = 2; clk_req_i = 1;
    wait_high("tp6_wait");
    rst_i = 1;
    step();
    chk("tp6_sd_clk", sd_clk_o, 0);
    chk("tp6_clk_en", clk_en_o, 0);
    chk("tp6_no_neg", neg_edge_o, 0);
    chk("tp6_stopped", clk_stopped_o, 1);
    rst_i = 0; clk_req_i = 0;
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) clk_req_i = ~clk_req_i;
      stop_req_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) div_i = 8'($urandom_range(0, 3));
      burst_start_i = ($urandom_range(0, 14) == 0);
      burst_len_i = 8'($urandom_range(0, 5));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
